// File: rtl/cpu_pkg.sv
// Shared constants for the core front end: data widths, the reset fetch
// address and the fetch-unit state encoding.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_pc_npc_sel.sv
// Redirect target select (jr > branch > jump) with the word-alignment check
// applied to jr and branch targets.
module npc_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] id_pc4,
    input  logic [15:0]       br_imm,
    input  logic [27:0]       jump_target28,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              jr,
    input  logic              br_taken,
    input  logic              jump,
    output logic              take,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);

    logic [ADDR_W-1:0] br_target;

    assign br_target = id_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign take      = jr | br_taken | jump;

    always_comb begin
        target     = {id_pc4[31:28], jump_target28};
        misaligned = 1'b0;
        if (jr) begin
            target     = jr_target;
            misaligned = addr_misaligned(jr_target[1:0]);
        end else if (br_taken) begin
            target     = br_target;
            misaligned = addr_misaligned(br_target[1:0]);
        end
    end

endmodule

// File: rtl/ifetch_pc.sv
// Instruction-fetch PC unit: next-PC selection, req/ack instruction-memory
// port and the valid/ready output register feeding decode.
module ifetch_pc
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [ADDR_W-1:0]  id_pc4,
    input  logic               br_taken,
    input  logic [15:0]        br_imm,
    input  logic               jump,
    input  logic [27:0]        jump_target28,
    input  logic               jr,
    input  logic [ADDR_W-1:0]  jr_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc4,
    input  logic               if_ready,
    output logic               fault
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_bad;

    logic              take;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              misaligned;
    logic              outstanding;
    logic              load_out;
    logic              active;

    npc_sel u_npc_sel (
        .id_pc4        (id_pc4),
        .br_imm        (br_imm),
        .jump_target28 (jump_target28),
        .jr_target     (jr_target),
        .jr            (jr),
        .br_taken      (br_taken),
        .jump          (jump),
        .take          (take),
        .target        (target),
        .misaligned    (misaligned)
    );

    assign redirect    = take & ~stall;
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign fault       = (state == ST_FAULT);
    assign active      = (state == ST_RUN) || (state == ST_WAIT);
    assign outstanding = imem_req & ~imem_ack;

    // A response is only kept when no redirect (same-cycle or pending) has made it wrong-path.
    assign load_out = imem_req & imem_ack & ~redirect &
                      ((state == ST_RUN) || ((state == ST_WAIT) && !pend_valid));

    always_comb begin
        imem_req = 1'b0;
        case (state)
            ST_RUN:  imem_req = ~stall & (~if_valid | if_ready);
            ST_WAIT: imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            pend_bad    <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (redirect) begin
                        // An unacknowledged request must be held, so park the target.
                        if (outstanding) begin
                            pend_valid  <= 1'b1;
                            pend_target <= target;
                            pend_bad    <= misaligned;
                            state       <= ST_WAIT;
                        end else if (misaligned) begin
                            state <= ST_FAULT;
                        end else begin
                            pc <= target;
                        end
                    end else if (imem_req) begin
                        if (imem_ack) pc <= pc_plus4;
                        else          state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        pend_valid <= 1'b0;
                        state      <= ST_RUN;
                        if (redirect) begin
                            if (misaligned) state <= ST_FAULT;
                            else            pc    <= target;
                        end else if (pend_valid) begin
                            if (pend_bad) state <= ST_FAULT;
                            else          pc    <= pend_target;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end else if (redirect) begin
                        pend_valid  <= 1'b1;
                        pend_target <= target;
                        pend_bad    <= misaligned;
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc4   <= '0;
        end else if (state == ST_FAULT) begin
            if_valid <= 1'b0;
        end else if (load_out) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc4   <= pc_plus4;
        end else if (active && redirect) begin
            if_valid <= 1'b0;
        end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_pc.sv
// Directed bench for ifetch_pc: sequential fetch, redirects, wait states,
// stall hold, misaligned-jr fault and asynchronous reset.
module tb_ifetch_pc;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] id_pc4;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jump;
    logic [27:0] jump_target28;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_ready;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    ifetch_pc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .id_pc4        (id_pc4),
        .br_taken      (br_taken),
        .br_imm        (br_imm),
        .jump          (jump),
        .jump_target28 (jump_target28),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc4        (if_pc4),
        .if_ready      (if_ready),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Memory model: each word is its address tagged in the upper half.
    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic j, input logic [31:0] jt, input logic b, input logic [15:0] imm,
                                 input logic jp, input logic [27:0] jt28, input logic [31:0] pc4);
        jr            = j;
        jr_target     = jt;
        br_taken      = b;
        br_imm        = imm;
        jump          = jp;
        jump_target28 = jt28;
        id_pc4        = pc4;
    endtask

    initial begin
        rst_n    = 1'b1;
        stall    = 1'b0;
        imem_ack = 1'b1;
        if_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_req",   imem_req,  0);
        checkOutput("rst_addr",  imem_addr, 32'h0000_3000);
        checkOutput("rst_valid", if_valid,  0);
        checkOutput("rst_instr", if_instr,  0);
        checkOutput("rst_pc4",   if_pc4,    0);
        checkOutput("rst_fault", fault,     0);

        rst_n = 1'b1;
        #1 checkOutput("boot_req", imem_req, 0);
        tick();
        checkOutput("seq0_req",  imem_req,  1);
        checkOutput("seq0_addr", imem_addr, 32'h0000_3000);
        tick();
        checkOutput("seq1_addr",  imem_addr, 32'h0000_3004);
        checkOutput("seq1_valid", if_valid,  1);
        checkOutput("seq1_instr", if_instr,  32'hDEAD_3000);
        checkOutput("seq1_pc4",   if_pc4,    32'h0000_3004);
        tick();
        checkOutput("seq2_addr", imem_addr, 32'h0000_3008);
        checkOutput("seq2_pc4",  if_pc4,    32'h0000_3008);

        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 28'h0000400, 32'h0000_3010);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        checkOutput("jmp_addr",  imem_addr, 32'h0000_0400);
        checkOutput("jmp_valid", if_valid,  0);
        tick();
        checkOutput("jmp_fetch_pc4", if_pc4, 32'h0000_0404);

        applyStimulus(1'b0, 32'h0, 1'b1, 16'hFFFE, 1'b0, 28'h0, 32'h0000_3020);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        checkOutput("br_addr",  imem_addr, 32'h0000_3018);
        checkOutput("br_valid", if_valid,  0);
        tick();
        checkOutput("br_instr", if_instr, 32'hDEAD_3018);
        checkOutput("br_pc4",   if_pc4,   32'h0000_301C);

        imem_ack = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 28'h0000800, 32'h0000_3010);
        checkOutput("w0_req",   imem_req,  1);
        checkOutput("w0_addr",  imem_addr, 32'h0000_301C);
        checkOutput("w0_valid", if_valid,  0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        checkOutput("w1_req",  imem_req,  1);
        checkOutput("w1_addr", imem_addr, 32'h0000_301C);
        tick();
        checkOutput("w2_addr", imem_addr, 32'h0000_301C);
        imem_ack = 1'b1;
        tick();
        checkOutput("wack_valid", if_valid,  0);
        checkOutput("wack_addr",  imem_addr, 32'h0000_0800);
        checkOutput("wack_req",   imem_req,  1);
        tick();
        checkOutput("wtgt_instr", if_instr, 32'hDEAD_0800);
        checkOutput("wtgt_pc4",   if_pc4,   32'h0000_0804);

        stall    = 1'b1;
        if_ready = 1'b0;
        #1 checkOutput("stall_req0", imem_req, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) applyStimulus(1'b0, 32'h0, 1'b1, 16'h0010, 1'b0, 28'h0, 32'h0000_3020);
            if (i == 1) applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
            checkOutput("stall_req",   imem_req,  0);
            checkOutput("stall_valid", if_valid,  1);
            checkOutput("stall_pc4",   if_pc4,    32'h0000_0804);
            checkOutput("stall_addr",  imem_addr, 32'h0000_0804);
        end
        stall    = 1'b0;
        if_ready = 1'b1;
        #1;
        checkOutput("unstall_req",  imem_req,  1);
        checkOutput("unstall_addr", imem_addr, 32'h0000_0804);
        tick();
        checkOutput("unstall_pc4", if_pc4, 32'h0000_0808);

        applyStimulus(1'b1, 32'h0000_3002, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("flt_fault", fault,    1);
            checkOutput("flt_req",   imem_req, 0);
            checkOutput("flt_valid", if_valid, 0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("flt_rst_fault", fault,     0);
        checkOutput("flt_rst_addr",  imem_addr, 32'h0000_3000);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("reboot_addr", imem_addr, 32'h0000_3000);

        applyStimulus(1'b1, 32'h0000_5000, 1'b1, 16'h0001, 1'b1, 28'h0000100, 32'h0000_3000);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 28'h0, 32'h0);
        checkOutput("prio_addr", imem_addr, 32'h0000_5000);

        imem_ack = 1'b0;
        tick();
        checkOutput("arst_wait_req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_req",  imem_req,  0);
        checkOutput("arst_addr", imem_addr, 32'h0000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
